// File: rtl/alarm_ctrl.sv
// alarm_ctrl: BCD alarm time register with arm/ring/snooze/stop sequencing on the 1 Hz tick.
module alarm_ctrl #(
  parameter int          RING_SECS   = 60,
  parameter int          SNOOZE_SECS = 300,
  parameter int          MAX_SNOOZE  = 3,
  parameter logic [7:0]  DEF_HH      = 8'h06,
  parameter logic [7:0]  DEF_MM      = 8'h00
) (
  input  logic       clk1hz,
  input  logic       rst,
  input  logic [7:0] t_hh,
  input  logic [7:0] t_mm,
  input  logic [7:0] t_ss,
  input  logic       alarm_en,
  input  logic       set_hr,
  input  logic       set_min,
  input  logic       snooze,
  input  logic       stop,
  output logic [7:0] alarm_hh,
  output logic [7:0] alarm_mm,
  output logic       armed,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzz,
  output logic [2:0] snooze_left
);
  // One-hot so every status output is a plain register bit.
  localparam logic [3:0] DISARMED = 4'b0001;
  localparam logic [3:0] ARMED    = 4'b0010;
  localparam logic [3:0] RINGING  = 4'b0100;
  localparam logic [3:0] SNOOZE   = 4'b1000;
  logic [3:0] state_q, state_d;
  logic [7:0] alarm_hh_q, alarm_hh_d, alarm_mm_q, alarm_mm_d, hh_inc, mm_inc;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic [9:0] snz_cnt_q, snz_cnt_d;
  logic [2:0] left_q, left_d;
  logic       buzz_q, buzz_d, set_ok, match;
  always_comb begin
    hh_inc = alarm_hh_q == 8'h23 ? 8'h00 :
             alarm_hh_q[3:0] == 4'd9 ? {alarm_hh_q[7:4] + 4'd1, 4'd0} : alarm_hh_q + 8'd1;
    mm_inc = alarm_mm_q == 8'h59 ? 8'h00 :
             alarm_mm_q[3:0] == 4'd9 ? {alarm_mm_q[7:4] + 4'd1, 4'd0} : alarm_mm_q + 8'd1;
    set_ok = state_q[0] | state_q[1];
    match = t_hh == alarm_hh_q && t_mm == alarm_mm_q && t_ss == 8'h00;
    alarm_hh_d = set_ok && set_hr ? hh_inc : alarm_hh_q;
    alarm_mm_d = set_ok && set_min ? mm_inc : alarm_mm_q;
    state_d = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d = snz_cnt_q;
    left_d = left_q;
    buzz_d = 1'b0;
    if (!alarm_en)
      state_d = DISARMED;
    else if (state_q[0])
      state_d = ARMED;
    else if (state_q[1]) begin
      if (match) begin
        state_d = RINGING;
        ring_cnt_d = 8'(RING_SECS - 1);
        left_d = 3'(MAX_SNOOZE);
        buzz_d = 1'b1;
      end
    end else if (state_q[2]) begin
      if (stop)
        state_d = ARMED;
      else if (snooze && left_q != 3'd0) begin
        state_d = SNOOZE;
        snz_cnt_d = 10'(SNOOZE_SECS - 1);
        left_d = left_q - 3'd1;
      end else if (ring_cnt_q == 8'd0)
        state_d = ARMED;
      else begin
        ring_cnt_d = ring_cnt_q - 8'd1;
        buzz_d = ~buzz_q;
      end
    end else if (state_q[3]) begin
      if (stop)
        state_d = ARMED;
      else if (snz_cnt_q == 10'd0) begin
        state_d = RINGING;
        ring_cnt_d = 8'(RING_SECS - 1);
        buzz_d = 1'b1;
      end else
        snz_cnt_d = snz_cnt_q - 10'd1;
    end else
      state_d = DISARMED;
  end
  always_ff @(posedge clk1hz) begin
    if (rst) begin
      state_q <= DISARMED;
      alarm_hh_q <= DEF_HH;
      alarm_mm_q <= DEF_MM;
      ring_cnt_q <= 8'd0;
      snz_cnt_q <= 10'd0;
      left_q <= 3'(MAX_SNOOZE);
      buzz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alarm_hh_q <= alarm_hh_d;
      alarm_mm_q <= alarm_mm_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q <= snz_cnt_d;
      left_q <= left_d;
      buzz_q <= buzz_d;
    end
  end
  assign alarm_hh = alarm_hh_q;
  assign alarm_mm = alarm_mm_q;
  assign armed = state_q[1];
  assign ringing = state_q[2];
  assign snoozing = state_q[3];
  assign buzz = buzz_q;
  assign snooze_left = left_q;
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed test-plan scenarios plus random traffic, checked every tick against a time-based model.
module tb_alarm_ctrl;
  localparam int RING_SECS = 60, SNOOZE_SECS = 300, MAX_SNOOZE = 3;
  localparam int OFF = 0, ARM = 1, RING = 2, SNZ = 3;
  logic clk1hz = 1'b0, rst = 1'b1;
  logic [7:0] t_hh = 8'h00, t_mm = 8'h00, t_ss = 8'h00;
  logic alarm_en = 1'b1, set_hr = 1'b0, set_min = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic [7:0] alarm_hh, alarm_mm;
  logic armed, ringing, snoozing, buzz;
  logic [2:0] snooze_left;
  int n_tests = 0, n_fail = 0, cyc = 0, tod = 0;
  int m_mode = OFF, m_ah = 6, m_am = 0, m_left = MAX_SNOOZE, m_rel = 0, m_sel = 0;

  alarm_ctrl #(.RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS), .MAX_SNOOZE(MAX_SNOOZE),
               .DEF_HH(8'h06), .DEF_MM(8'h00)) dut (
    .clk1hz(clk1hz), .rst(rst), .t_hh(t_hh), .t_mm(t_mm), .t_ss(t_ss),
    .alarm_en(alarm_en), .set_hr(set_hr), .set_min(set_min), .snooze(snooze), .stop(stop),
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .armed(armed), .ringing(ringing),
    .snoozing(snoozing), .buzz(buzz), .snooze_left(snooze_left));

  always #5 clk1hz = ~clk1hz;

  function automatic logic [7:0] bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Model: alarm kept as plain hour/minute integers; ring and snooze timers count elapsed seconds upward.
  task automatic model_step();
    bit match, setok;
    if (rst) begin
      m_mode = OFF; m_ah = 6; m_am = 0; m_left = MAX_SNOOZE; m_rel = 0; m_sel = 0;
      return;
    end
    setok = m_mode == OFF || m_mode == ARM;
    match = t_hh == bcd(m_ah) && t_mm == bcd(m_am) && t_ss == 8'h00;
    if (!alarm_en) m_mode = OFF;
    else if (m_mode == OFF) m_mode = ARM;
    else if (m_mode == ARM) begin
      if (match) begin m_mode = RING; m_rel = 0; m_left = MAX_SNOOZE; end
    end else if (m_mode == RING) begin
      if (stop) m_mode = ARM;
      else if (snooze && m_left > 0) begin m_mode = SNZ; m_sel = 0; m_left--; end
      else if (m_rel == RING_SECS - 1) m_mode = ARM;
      else m_rel++;
    end else begin
      if (stop) m_mode = ARM;
      else if (m_sel == SNOOZE_SECS - 1) begin m_mode = RING; m_rel = 0; end
      else m_sel++;
    end
    if (setok) begin
      if (set_hr) m_ah = (m_ah + 1) % 24;
      if (set_min) m_am = (m_am + 1) % 60;
    end
  endtask

  always @(negedge clk1hz) begin
    logic [7:0] ehh, emm;
    logic ea, er, es, eb;
    logic [2:0] el;
    ehh = bcd(m_ah); emm = bcd(m_am);
    ea = m_mode == ARM; er = m_mode == RING; es = m_mode == SNZ;
    eb = m_mode == RING && m_rel % 2 == 0;
    el = 3'(m_left);
    n_tests++;
    if ({alarm_hh, alarm_mm, armed, ringing, snoozing, buzz, snooze_left} !==
        {ehh, emm, ea, er, es, eb, el}) begin
      n_fail++;
      $display("FAIL model cyc %0d: got hh=%h mm=%h a=%b r=%b s=%b bz=%b left=%0d, expected hh=%h mm=%h a=%b r=%b s=%b bz=%b left=%0d",
               cyc, alarm_hh, alarm_mm, armed, ringing, snoozing, buzz, snooze_left,
               ehh, emm, ea, er, es, eb, el);
    end
  end

  task automatic lit(string nm, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive();
    t_hh = bcd(tod / 3600); t_mm = bcd((tod / 60) % 60); t_ss = bcd(tod % 60);
  endtask

  task automatic tick();
    @(posedge clk1hz);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic adv(int n);
    repeat (n) begin
      tick();
      tod = (tod + 1) % 86400;
      drive();
    end
  endtask

  initial begin
    tod = 21598; drive();
    adv(1);
    lit("reset_hh", alarm_hh, 8'h06); lit("reset_mm", alarm_mm, 8'h00);
    lit("reset_armed", 8'(armed), 8'h0); lit("reset_buzz", 8'(buzz), 8'h0);
    lit("reset_left", 8'(snooze_left), 8'h3);
    rst = 1'b0;
    adv(1); lit("arm_tick1", 8'(armed), 8'h1);
    adv(1); lit("match_ring", 8'(ringing), 8'h1); lit("match_buzz", 8'(buzz), 8'h1);
    adv(1); lit("buzz_toggle", 8'(buzz), 8'h0);
    adv(57); lit("ring_59", 8'(ringing), 8'h1);
    adv(1); lit("ring_60", 8'(ringing), 8'h1); lit("ring_60_buzz", 8'(buzz), 8'h0);
    adv(1); lit("ring_timeout", 8'(armed), 8'h1);
    set_hr = 1'b1; adv(20); set_hr = 1'b0;
    lit("set_hr_wrap", alarm_hh, 8'h02);
    set_min = 1'b1; adv(61); set_min = 1'b0;
    lit("set_min_wrap", alarm_mm, 8'h01); lit("set_min_hh", alarm_hh, 8'h02);
    tod = 7261; drive(); adv(2);
    lit("no_ring_01", 8'(ringing), 8'h0);
    tod = 7259; drive(); adv(2);
    lit("ring_0201", 8'(ringing), 8'h1);
    set_hr = 1'b1; adv(1); set_hr = 1'b0;
    lit("set_in_ring", alarm_hh, 8'h02);
    snooze = 1'b1; adv(1); snooze = 1'b0;
    lit("snooze_on", 8'(snoozing), 8'h1); lit("snooze_left2", 8'(snooze_left), 8'h2);
    adv(299); lit("snooze_300", 8'(snoozing), 8'h1);
    adv(1); lit("snooze_end", 8'(ringing), 8'h1); lit("snooze_end_buzz", 8'(buzz), 8'h1);
    repeat (2) begin
      snooze = 1'b1; adv(1); snooze = 1'b0;
      adv(300);
    end
    snooze = 1'b1; adv(1); snooze = 1'b0;
    lit("snooze4_ring", 8'(ringing), 8'h1); lit("snooze4_left", 8'(snooze_left), 8'h0);
    stop = 1'b1; adv(1); stop = 1'b0;
    lit("stop_ring", 8'(armed), 8'h1);
    tod = 7259; drive(); adv(2);
    lit("next_day_ring", 8'(ringing), 8'h1); lit("next_day_left", 8'(snooze_left), 8'h3);
    snooze = 1'b1; adv(1); snooze = 1'b0;
    stop = 1'b1; adv(1); stop = 1'b0;
    lit("stop_snooze", 8'(armed), 8'h1);
    tod = 7259; drive(); adv(2);
    alarm_en = 1'b0; adv(1); alarm_en = 1'b1;
    lit("en_off_ring", 8'(ringing), 8'h0); lit("en_off_buzz", 8'(buzz), 8'h0);
    lit("en_off_armed", 8'(armed), 8'h0);
    adv(1); lit("rearm", 8'(armed), 8'h1);
    tod = 7259; drive(); adv(2);
    rst = 1'b1; adv(1); rst = 1'b0;
    lit("rst_ring", 8'(ringing), 8'h0); lit("rst_buzz", 8'(buzz), 8'h0);
    lit("rst_hh", alarm_hh, 8'h06); lit("rst_mm", alarm_mm, 8'h00);
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      alarm_en = $urandom_range(0, 59) != 0;
      set_hr = $urandom_range(0, 24) == 0;
      set_min = $urandom_range(0, 19) == 0;
      snooze = $urandom_range(0, 14) == 0;
      stop = $urandom_range(0, 79) == 0;
      if ($urandom_range(0, 149) == 0) tod = (m_ah * 3600 + m_am * 60 + 86399) % 86400;
      drive();
      if ($urandom_range(0, 49) == 0) t_hh = 8'($urandom);
      if ($urandom_range(0, 49) == 0) t_ss = 8'($urandom);
      tick();
      tod = (tod + 1) % 86400;
    end
    @(negedge clk1hz); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm unit directly downstream of the BCD time-of-day counter. Runs on the same 1 Hz tick and holds a user-settable alarm time (BCD hh:mm). It compares that time against the live time digits and sequences ring, snooze and stop through a small state machine. Its outputs drive the buzzer pin and the alarm-status LEDs, and supply the alarm time to the display mux in alarm-view mode.

## Interface
Parameters:
- RING_SECS, 60 — seconds an alarm rings before auto-stop (1..255)
- SNOOZE_SECS, 300 — snooze duration in seconds (1..1023)
- MAX_SNOOZE, 3 — snoozes allowed per alarm event (0..7)
- DEF_HH, 8'h06 — BCD alarm hour after reset
- DEF_MM, 8'h00 — BCD alarm minute after reset

Ports:
- clk1hz  in  1  1 Hz clock, same clock as the time counter
- rst  in  1  reset, synchronous, active-high
- t_hh  in  8  live BCD hours {tens, units}, 00..23
- t_mm  in  8  live BCD minutes, 00..59
- t_ss  in  8  live BCD seconds, 00..59
- alarm_en  in  1  level; 0 forces DISARMED
- set_hr  in  1  level; while high, alarm hour increments once per tick
- set_min  in  1  level; while high, alarm minute increments once per tick
- snooze  in  1  level, sampled each tick
- stop  in  1  level, sampled each tick
- alarm_hh  out  8  BCD alarm hour
- alarm_mm  out  8  BCD alarm minute
- armed  out  1  state == ARMED
- ringing  out  1  state == RINGING
- snoozing  out  1  state == SNOOZE
- buzz  out  1  buzzer drive, toggles each tick while ringing
- snooze_left  out  3  snoozes remaining in the current event

## Operation
- States: DISARMED, ARMED, RINGING, SNOOZE. All outputs are registered.
- Transition priority, evaluated at each clk1hz edge: rst > !alarm_en > stop > snooze > timer expiry > time match.
- DISARMED: moves to ARMED when alarm_en=1.
- ARMED: moves to RINGING when t_hh==alarm_hh && t_mm==alarm_mm && t_ss==8'h00. On entry, ring_cnt loads RING_SECS-1.
- RINGING:
  - stop=1 → ARMED.
  - snooze=1 with snooze_left>0 → SNOOZE. snz_cnt loads SNOOZE_SECS-1 and snooze_left decrements.
  - snooze=1 with snooze_left==0 is ignored.
  - ring_cnt==0 → ARMED. Otherwise ring_cnt decrements.
- SNOOZE:
  - stop=1 → ARMED.
  - snz_cnt==0 → RINGING, with ring_cnt reloaded. Otherwise snz_cnt decrements.
  - snooze input is ignored.
- snooze_left reloads to MAX_SNOOZE on every ARMED→RINGING transition and on reset.
- Setting the alarm time:
  - set_hr: alarm_hh increments in BCD, 09→10, 19→20, 23→00.
  - set_min: alarm_mm increments in BCD, 09→10, 59→00. No carry into the hour.
  - Both high: both fields increment in the same tick.
  - Setting is honoured only in DISARMED and ARMED. It is ignored in RINGING and SNOOZE.
  - A set in the same tick as a match: the match uses the pre-increment alarm value.
- buzz: set to 1 on entry to RINGING, inverted on each subsequent tick while in RINGING, and 0 in every other state.
- Width rules:
  - ring_cnt is 8 bits and snz_cnt is 10 bits.
  - Both counters hold their value outside their own state.
  - Comparison is pure bitwise equality. Invalid BCD inputs never cause a match unless alarm_hh/alarm_mm hold the same invalid pattern, which cannot occur because they only ever hold valid BCD.

## Timing
- Reset values: alarm_hh=DEF_HH, alarm_mm=DEF_MM, state DISARMED, armed=0, ringing=0, snoozing=0, buzz=0, snooze_left=MAX_SNOOZE, both counters 0.
- First tick after rst deasserts with alarm_en=1 → armed=1.
- Match latency: inputs showing the alarm time at :00 on edge k → ringing=1 and buzz=1 after edge k.
- Ring duration: exactly RING_SECS ticks with ringing=1, then armed=1.
- Snooze duration: exactly SNOOZE_SECS ticks with snoozing=1, then ringing=1.
- Control inputs take effect one tick later (registered). Pulses narrower than one clk1hz period may be missed. Debouncing and stretching are the upstream button block's job.
- rst asserted in any state → reset values after that edge, and alarm_hh/alarm_mm return to their defaults.
- alarm_en deasserted mid-ring or mid-snooze → DISARMED next tick, buzz=0.

## Test plan
- Reset, alarm_en=1, time 06:00:00 with default alarm → armed=1 at tick 1, ringing=1 after the match tick, buzz sequence 1,0,1,…, back to armed after 60 ringing ticks.
- Hold set_hr for 20 ticks from 06 → alarm_hh = 8'h02 (wraps past 23). Hold set_min for 61 ticks from 00 → alarm_mm = 8'h01, with alarm_hh unchanged.
- Ringing, snooze pulse → snoozing=1 and snooze_left=2, ringing=1 again after 300 ticks. Fourth snooze attempt, with snooze_left=0, is ignored and ringing continues.
- stop during SNOOZE → armed=1 next tick. The same hh:mm:00 reached the next day → rings again with snooze_left reloaded to 3.
- Time 06:00:01 presented without a preceding 06:00:00 → no ring. set_hr held during RINGING → alarm_hh unchanged.
- rst or alarm_en=0 asserted during RINGING → ringing=0 and buzz=0 next tick. After rst, alarm time is back to 06:00.
